mem_burst_reader: RTL

//   Read-side engine for the 32x16 register-file memory.
//   On a start command it walks burst_len consecutive entries from base_addr, wrapping modulo 16.
//   It drives one combinational read port (rd_addr -> rd_data).
//   It streams each word out on a valid/ready interface with full backpressure and a last marker.
//   It sits between the register file and any downstream consumer (DMA, debug dump, checksum).

---
 rtl/mem_rd_pkg.sv | 16 +
 rtl/mem_rd_out_stage.sv | 37 +++
 rtl/mem_burst_reader.sv | 109 ++++++++++
 3 files changed

// File: rtl/mem_rd_pkg.sv
// Shared constants and FSM state type for the register-file burst reader.
package mem_rd_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  localparam logic [ADDR_W:0] LEN_ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

endpackage

// File: rtl/mem_rd_out_stage.sv
// Single-entry valid/ready register slice holding one output beat (data + last).
module mem_rd_out_stage
  import mem_rd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic              can_load,
  output logic              accept
);

  assign accept   = valid && ready;
  assign can_load = !valid || ready;

  // A load replaces an accepted beat in the same cycle, giving one beat per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      last  <= load_last;
    end else if (accept) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read engine: walks burst_len entries from base_addr (wrapping) through a
// combinational read port and streams them out over valid/ready with a last marker.
module mem_burst_reader
  import mem_rd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   burst_len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  state_t            state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] rd_addr_hold;
  logic [ADDR_W:0]   remaining;
  logic              accept_start;
  logic              load;
  logic              load_last;
  logic              can_load;
  logic              beat_accept;

  assign accept_start = (state == IDLE) && start && (burst_len != '0);
  assign busy         = (state != IDLE);

  // The first word is captured on the accepting edge itself, so the read port
  // presents base_addr during the start cycle.
  always_comb begin
    rd_addr   = rd_addr_hold;
    load      = 1'b0;
    load_last = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept_start) begin
          rd_addr   = base_addr;
          load      = 1'b1;
          load_last = (burst_len == LEN_ONE);
        end
      end
      STREAM: begin
        rd_addr   = cur_addr;
        load      = can_load;
        load_last = (remaining == LEN_ONE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur_addr     <= '0;
      remaining    <= '0;
      rd_addr_hold <= '0;
      done         <= 1'b0;
    end else begin
      rd_addr_hold <= rd_addr;
      done         <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept_start) begin
            cur_addr  <= base_addr + 1'b1;
            remaining <= burst_len - LEN_ONE;
            state     <= (burst_len == LEN_ONE) ? DRAIN : STREAM;
          end
        end
        STREAM: begin
          if (load) begin
            cur_addr  <= cur_addr + 1'b1;
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (beat_accept) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mem_rd_out_stage u_out_stage (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (rd_data),
    .load_last (load_last),
    .ready     (out_ready),
    .valid     (out_valid),
    .data      (out_data),
    .last      (out_last),
    .can_load  (can_load),
    .accept    (beat_accept)
  );

endmodule
